// File: rtl/commit_monitor.sv
// commit_monitor -- checks a CPU's retired-instruction stream for control-flow
// consistency, a correct first PC, a halt PC and hangs. It also keeps a 4-deep
// ring of recently committed PCs.
//
// States:
//   state  | meaning
//   IDLE   | out of reset, no commit yet; the first commit must carry RESET_PC
//   RUN    | commits accepted; each commit must match the previous commit_pre_pc
//   HALT   | HALT_PC was committed; everything frozen until reset
//   FAIL   | bad first PC, flow mismatch or timeout; everything frozen until reset
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   commit          a retired instruction is presented this cycle
//   commit_pc       PC of the retired instruction
//   commit_pre_pc   next PC that instruction actually produced
//   trace_idx       trace age select (0 = newest)
//   trace_pc        committed PC at age trace_idx (combinational read)
//   commit_cnt      accepted commits (wraps)
//   cycle_cnt       cycles spent in IDLE or RUN (saturates)
//   done, fail      state is HALT / FAIL
//   err_code        0 none, 1 bad first PC, 2 flow mismatch, 3 timeout
//   err_pc          offending commit_pc, or the expected PC on a timeout
//   err_exp_pc      PC that was expected at failure
module commit_monitor #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h8000_0000),
  parameter logic [PC_WIDTH-1:0] HALT_PC  = PC_WIDTH'(32'h8000_0FFC),
  parameter int                  TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                commit,
  input  logic [PC_WIDTH-1:0] commit_pc,
  input  logic [PC_WIDTH-1:0] commit_pre_pc,
  input  logic [1:0]          trace_idx,
  output logic [PC_WIDTH-1:0] trace_pc,
  output logic [31:0]         commit_cnt,
  output logic [31:0]         cycle_cnt,
  output logic                done,
  output logic                fail,
  output logic [1:0]          err_code,
  output logic [PC_WIDTH-1:0] err_pc,
  output logic [PC_WIDTH-1:0] err_exp_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] exp_pc;
  logic [31:0]         idle_cnt;
  logic [PC_WIDTH-1:0] ring [4];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;

  logic active;
  logic mismatch;
  logic accept;
  logic timeout;

  assign active = (state == S_IDLE) || (state == S_RUN);
  // exp_pc holds RESET_PC throughout IDLE, so the same compare covers the first-PC check.
  assign mismatch = commit && (commit_pc != exp_pc);
  assign accept   = active && commit && !mismatch;
  assign timeout  = active && !commit && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (commit) begin
          if (mismatch)                state_nxt = S_FAIL;
          else if (commit_pc == HALT_PC) state_nxt = S_HALT;
          else                         state_nxt = S_RUN;
        end else if (timeout) begin
          state_nxt = S_FAIL;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_pc     <= RESET_PC;
      idle_cnt   <= '0;
      commit_cnt <= '0;
      cycle_cnt  <= '0;
      wr_ptr     <= '0;
      err_code   <= '0;
      err_pc     <= '0;
      err_exp_pc <= '0;
      for (int i = 0; i < 4; i++) ring[i] <= '0;
    end else if (active) begin
      if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
      idle_cnt <= commit ? '0 : idle_cnt + 32'd1;

      if (accept) begin
        commit_cnt   <= commit_cnt + 32'd1;
        ring[wr_ptr] <= commit_pc;
        wr_ptr       <= wr_ptr + 2'd1;
        exp_pc       <= commit_pre_pc;
      end

      if (mismatch) begin
        err_code   <= (state == S_IDLE) ? 2'd1 : 2'd2;
        err_pc     <= commit_pc;
        err_exp_pc <= exp_pc;
      end else if (timeout) begin
        err_code   <= 2'd3;
        err_pc     <= exp_pc;
        err_exp_pc <= exp_pc;
      end
    end
  end

  // Newest entry sits just behind the write pointer; 2-bit arithmetic wraps mod 4.
  assign rd_ptr   = wr_ptr - 2'd1 - trace_idx;
  assign trace_pc = ring[rd_ptr];

  assign done = (state == S_HALT);
  assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor: the driver predicts each cycle's
// outputs from a behavioural model and queues them; a monitor on the falling
// edge pops and compares.
module tb_commit_monitor;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] HLT_PC  = 32'h8000_0FFC;
  localparam int          TMO     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_pre_pc = '0;
  logic [1:0]  trace_idx = '0;
  logic [31:0] trace_pc;
  logic [31:0] commit_cnt;
  logic [31:0] cycle_cnt;
  logic        done;
  logic        fail;
  logic [1:0]  err_code;
  logic [31:0] err_pc;
  logic [31:0] err_exp_pc;

  int n_chk  = 0;
  int n_fail = 0;

  commit_monitor #(
    .PC_WIDTH(32), .RESET_PC(RST_PC), .HALT_PC(HLT_PC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc),
    .commit_pre_pc(commit_pre_pc), .trace_idx(trace_idx), .trace_pc(trace_pc),
    .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt), .done(done), .fail(fail),
    .err_code(err_code), .err_pc(err_pc), .err_exp_pc(err_exp_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] trace;
    logic [31:0] cnt;
    logic [31:0] cyc;
    logic        done;
    logic        fail;
    logic [1:0]  code;
    logic [31:0] epc;
    logic [31:0] eexp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: run status flags, history of accepted PCs (newest first),
  // and the length of the current commit-free stretch.
  bit          m_started, m_done, m_fail;
  logic [31:0] m_exp, m_cnt, m_cyc, m_epc, m_eexp;
  logic [1:0]  m_code;
  int          m_gap;
  logic [31:0] m_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_trace(input logic [1:0] idx);
    if (int'(idx) < m_hist.size()) return m_hist[idx];
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_started = 0; m_done = 0; m_fail = 0;
    m_exp = RST_PC; m_cnt = 0; m_cyc = 0;
    m_code = 0; m_epc = 0; m_eexp = 0;
    m_gap = 0;
    m_hist.delete();
  endtask

  task automatic m_clock(input logic c, input logic [31:0] pc, input logic [31:0] pre);
    if (m_done || m_fail) return;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (c) begin
      m_gap = 0;
      if (pc != m_exp) begin
        m_fail = 1;
        m_code = m_started ? 2'd2 : 2'd1;
        m_epc  = pc;
        m_eexp = m_exp;
      end else begin
        m_cnt++;
        m_hist.push_front(pc);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        m_exp = pre;
        m_started = 1;
        if (pc == HLT_PC) m_done = 1;
      end
    end else begin
      m_gap++;
      if (m_gap >= TMO) begin
        m_fail = 1;
        m_code = 2'd3;
        m_epc  = m_exp;
        m_eexp = m_exp;
      end
    end
  endtask

  task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] pre,
                      input logic [1:0] idx);
    exp_t e;
    @(negedge clk); #1;
    rst = 1'b1; commit = c; commit_pc = pc; commit_pre_pc = pre; trace_idx = idx;
    m_clock(c, pc, pre);
    @(posedge clk);
    e.trace = m_trace(idx); e.cnt = m_cnt; e.cyc = m_cyc;
    e.done = m_done; e.fail = m_fail; e.code = m_code;
    e.epc = m_epc; e.eexp = m_eexp;
    sb.push_back(e);
    #1;
  endtask

  task automatic do_reset(input bit check_zero);
    @(negedge clk); #1;
    rst = 1'b0; commit = 1'b0;
    #1;
    if (check_zero) begin
      chk("rst_trace_pc", trace_pc, 0);
      chk("rst_commit_cnt", commit_cnt, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fail", 32'(fail), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_err_pc", err_pc, 0);
      chk("rst_err_exp_pc", err_exp_pc, 0);
    end
    m_reset();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_trace_pc", trace_pc, mon_e.trace);
      chk("sb_commit_cnt", commit_cnt, mon_e.cnt);
      chk("sb_cycle_cnt", cycle_cnt, mon_e.cyc);
      chk("sb_done", 32'(done), 32'(mon_e.done));
      chk("sb_fail", 32'(fail), 32'(mon_e.fail));
      chk("sb_err_code", 32'(err_code), 32'(mon_e.code));
      chk("sb_err_pc", err_pc, mon_e.epc);
      chk("sb_err_exp_pc", err_exp_pc, mon_e.eexp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, pre;
    logic        c;
    int          prob;

    m_reset();
    do_reset(1'b1);

    // Two sequential commits, then a reset while in RUN.
    step(1, 32'h8000_0000, 32'h8000_0004, 2'd0);
    step(1, 32'h8000_0004, 32'h8000_0008, 2'd0);
    chk("seq_cnt", commit_cnt, 2);
    chk("seq_trace0", trace_pc, 32'h8000_0004);
    step(0, 32'h0, 32'h0, 2'd1);
    chk("seq_trace1", trace_pc, 32'h8000_0000);
    chk("seq_fail", 32'(fail), 0);
    do_reset(1'b1);

    // Bad first PC.
    step(1, 32'h8000_0010, 32'h8000_0014, 2'd0);
    chk("bad_first_fail", 32'(fail), 1);
    chk("bad_first_code", 32'(err_code), 1);
    chk("bad_first_pc", err_pc, 32'h8000_0010);
    chk("bad_first_exp", err_exp_pc, 32'h8000_0000);
    do_reset(1'b0);

    // Flow mismatch after a taken jump.
    step(1, 32'h8000_0000, 32'h8000_0100, 2'd0);
    step(1, 32'h8000_0004, 32'h8000_0008, 2'd0);
    chk("mism_code", 32'(err_code), 2);
    chk("mism_pc", err_pc, 32'h8000_0004);
    chk("mism_exp", err_exp_pc, 32'h8000_0100);
    chk("mism_cnt", commit_cnt, 1);
    do_reset(1'b0);

    // Timeout: one commit then TMO commit-free cycles.
    step(1, RST_PC, 32'h8000_0004, 2'd0);
    for (int i = 0; i < TMO - 1; i++) step(0, 32'h0, 32'h0, 2'd0);
    chk("tmo_not_yet", 32'(fail), 0);
    step(0, 32'h0, 32'h0, 2'd0);
    chk("tmo_fail", 32'(fail), 1);
    chk("tmo_code", 32'(err_code), 3);
    chk("tmo_err_pc", err_pc, 32'h8000_0004);
    do_reset(1'b0);

    // Six commits ending at HALT_PC, then ignored commits.
    step(1, 32'h8000_0000, 32'h8000_0FEC, 2'd0);
    pc = 32'h8000_0FEC;
    for (int i = 0; i < 5; i++) begin
      step(1, pc, pc + 32'd4, 2'd0);
      pc = pc + 32'd4;
    end
    chk("halt_done", 32'(done), 1);
    chk("halt_cnt", commit_cnt, 6);
    chk("halt_trace0", trace_pc, HLT_PC);
    step(1, 32'h8000_1000, 32'h8000_1004, 2'd0);
    step(1, 32'h1234_5678, 32'h0, 2'd0);
    chk("halt_frozen_cnt", commit_cnt, 6);
    chk("halt_frozen_trace", trace_pc, HLT_PC);
    chk("halt_frozen_done", 32'(done), 1);
    chk("halt_frozen_fail", 32'(fail), 0);

    // Randomized runs against the model.
    for (int run = 0; run < 15; run++) begin
      do_reset(1'b0);
      prob = (run % 3 == 0) ? 3 : 8;
      for (int n = 0; n < 60; n++) begin
        c  = ($urandom_range(0, 9) < prob);
        pc = ($urandom_range(0, 19) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_exp;
        case ($urandom_range(0, 9))
          0:       pre = HLT_PC;
          1:       pre = $urandom & 32'hFFFF_FFFC;
          default: pre = pc + 32'd4;
        endcase
        step(c, pc, pre, 2'($urandom_range(0, 3)));
      end
    end

    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
